// File: rtl/matrix_uart_printer.sv
// Purpose : latches a 4x4 matrix on start and streams it as uppercase-hex ASCII text into a byte UART.
// Latency : first transmit is 2 cycles after an accepted start; then 3 cycles per byte plus the UART busy time.
// Backpress: every byte waits for is_transmitting low, then waits for it to rise and fall again.
//
// Ports:
//   clk, reset (async, active-low)
//   start           - 1-cycle request, sampled only while idle
//   mat_i           - 16 elements, element [r][c] at bits [(4*r+c)*DATA_W +: DATA_W]
//   is_transmitting - UART busy flag
//   transmit        - 1-cycle pulse; tx_byte is valid in the same cycle
//   tx_byte         - current ASCII character
//   busy            - high from an accepted start until done
//   done            - 1-cycle pulse after the last byte has left the UART
module matrix_uart_printer #(
    parameter int DATA_W = 32,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [16*DATA_W-1:0]  mat_i,
    input  logic                  is_transmitting,
    output logic                  transmit,
    output logic [7:0]            tx_byte,
    output logic                  busy,
    output logic                  done
);
    localparam int ELEM_W  = DIGITS * 4;
    localparam int HDR_LEN = 16;
    localparam int ROW_LEN = 12 + 4 * DIGITS;
    localparam int MSG_LEN = HDR_LEN + 4 * ROW_LEN + 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_READY = 3'd2;
    localparam logic [2:0] S_ACK   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]        r_state;
    logic [7:0]        r_idx;   // byte index within the whole message
    logic [5:0]        r_off;   // position within the current matrix row line
    logic [1:0]        r_row;
    logic [1:0]        r_col;
    logic [3:0]        r_dig;   // 0..DIGITS-1 hex digits, then two separator slots
    logic [7:0]        r_tx_byte;
    logic              r_busy;
    logic [ELEM_W-1:0] r_mat [16];

    logic [ELEM_W-1:0] w_elem;
    logic [ELEM_W-1:0] w_shifted;
    logic [5:0]        w_shamt;
    logic [3:0]        w_nib;
    logic [7:0]        w_hex;
    logic [7:0]        w_char;
    logic              w_unused_mat;

    // Bits above the printed width are intentionally discarded.
    assign w_unused_mat = ^mat_i;

    function automatic logic [7:0] hdr_char(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h54; // T
            4'd1:    return 8'h68; // h
            4'd2:    return 8'h65; // e
            4'd3:    return 8'h20;
            4'd4:    return 8'h72; // r
            4'd5:    return 8'h65; // e
            4'd6:    return 8'h73; // s
            4'd7:    return 8'h75; // u
            4'd8:    return 8'h6C; // l
            4'd9:    return 8'h74; // t
            4'd10:   return 8'h20;
            4'd11:   return 8'h69; // i
            4'd12:   return 8'h73; // s
            4'd13:   return 8'h3A; // :
            4'd14:   return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    // Character generator: header by index, trailer by index, row text from the row counters.
    always_comb begin
        w_elem    = r_mat[{r_row, r_col}];
        // Digit 0 is the most significant nibble; garbage shift for separator slots is never used.
        w_shamt   = 6'(4 * (DIGITS - 1)) - {r_dig, 2'b00};
        w_shifted = w_elem >> w_shamt;
        w_nib     = w_shifted[3:0];
        w_hex     = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h37 + {4'h0, w_nib});
        w_char    = 8'h00;
        if (r_idx < 8'(HDR_LEN))               w_char = hdr_char(r_idx[3:0]);
        else if (r_idx == 8'(MSG_LEN - 2))     w_char = 8'h0D;
        else if (r_idx == 8'(MSG_LEN - 1))     w_char = 8'h0A;
        else if (r_off == 6'd0)                w_char = 8'h5B; // [
        else if (r_off == 6'd1)                w_char = 8'h20;
        else if (r_off == 6'(ROW_LEN - 2))     w_char = 8'h0D;
        else if (r_off == 6'(ROW_LEN - 1))     w_char = 8'h0A;
        else if (r_dig < 4'(DIGITS))           w_char = w_hex;
        else if (r_dig == 4'(DIGITS))          w_char = (r_col == 2'd3) ? 8'h20 : 8'h2C;
        else                                   w_char = (r_col == 2'd3) ? 8'h5D : 8'h20;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_off     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_dig     <= '0;
            r_tx_byte <= 8'h00;
            r_busy    <= 1'b0;
            for (int i = 0; i < 16; i++) r_mat[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < 16; i++) r_mat[i] <= mat_i[i*DATA_W +: ELEM_W];
                        r_busy  <= 1'b1;
                        r_idx   <= '0;
                        r_off   <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_dig   <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_tx_byte <= w_char;
                    r_state   <= S_READY;
                end
                S_READY: begin
                    if (!is_transmitting) r_state <= S_ACK;
                end
                S_ACK: begin
                    if (is_transmitting) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!is_transmitting) begin
                        if (r_idx == 8'(MSG_LEN - 1)) begin
                            r_state <= S_FIN;
                        end else begin
                            r_idx   <= r_idx + 8'd1;
                            r_state <= S_FETCH;
                            // Row counters only move once past the header line.
                            if (r_idx >= 8'(HDR_LEN)) begin
                                if (r_off == 6'(ROW_LEN - 1)) begin
                                    r_off <= '0;
                                    r_row <= r_row + 2'd1;
                                    r_col <= '0;
                                    r_dig <= '0;
                                end else begin
                                    r_off <= r_off + 6'd1;
                                    if (r_off >= 6'd2) begin
                                        if (r_dig == 4'(DIGITS + 1)) begin
                                            r_dig <= '0;
                                            r_col <= r_col + 2'd1;
                                        end else begin
                                            r_dig <= r_dig + 4'd1;
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign transmit = (r_state == S_READY) && !is_transmitting;
    assign tx_byte  = r_tx_byte;
    assign busy     = r_busy;
    assign done     = (r_state == S_FIN);
endmodule

// File: tb/tb_matrix_uart_printer.sv
module tb_matrix_uart_printer;
    localparam int L4 = 130;
    localparam int L2 = 98;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start;
    logic [1:0] hold;
    logic [1:0] is_tx;
    logic [1:0] transmit;
    logic [1:0] busy;
    logic [1:0] done;
    logic [7:0] txb [2];
    logic [511:0] mat [2];
    int ucnt [2] = '{0, 0};

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [2][$];
    int n_tx [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};

    always #5 clk = ~clk;

    matrix_uart_printer #(.DATA_W(32), .DIGITS(4)) dut0 (
        .clk(clk), .reset(rst_n), .start(start[0]), .mat_i(mat[0]),
        .is_transmitting(is_tx[0]), .transmit(transmit[0]), .tx_byte(txb[0]),
        .busy(busy[0]), .done(done[0])
    );

    matrix_uart_printer #(.DATA_W(32), .DIGITS(2)) dut1 (
        .clk(clk), .reset(rst_n), .start(start[1]), .mat_i(mat[1]),
        .is_transmitting(is_tx[1]), .transmit(transmit[1]), .tx_byte(txb[1]),
        .busy(busy[1]), .done(done[1])
    );

    // UART model: busy for 10 cycles, starting one cycle after the transmit pulse.
    assign is_tx[0] = hold[0] | (ucnt[0] >= 1 && ucnt[0] <= 10);
    assign is_tx[1] = hold[1] | (ucnt[1] >= 1 && ucnt[1] <= 10);

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (transmit[d] === 1'b1) ucnt[d] <= 11;
            else if (ucnt[d] > 0)     ucnt[d] <= ucnt[d] - 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected character per transmit pulse.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (transmit[d] === 1'b1) begin
                n_tx[d]++;
                if (exp_q[d].size() == 0) chk("extra_byte", 1, 0);
                else chk("tx_byte", int'(txb[d]), int'(exp_q[d].pop_front()));
            end
            if (done[d] === 1'b1) begin
                done_cnt[d]++;
                chk("queue_empty_at_done", exp_q[d].size(), 0);
            end
        end
    end

    // Reference text built directly from the message layout.
    task automatic push_text(input int d, input logic [511:0] m, input int D);
        string hx  = "0123456789ABCDEF";
        string hdr = "The result is:";
        logic [31:0] e;
        for (int i = 0; i < hdr.len(); i++) exp_q[d].push_back(hdr[i]);
        exp_q[d].push_back(8'h0D); exp_q[d].push_back(8'h0A);
        for (int r = 0; r < 4; r++) begin
            exp_q[d].push_back(8'h5B); exp_q[d].push_back(8'h20);
            for (int c = 0; c < 4; c++) begin
                e = m[(4*r+c)*32 +: 32];
                for (int k = 0; k < D; k++) exp_q[d].push_back(hx[int'((e >> (4*(D-1-k))) & 32'hF)]);
                if (c < 3) begin exp_q[d].push_back(8'h2C); exp_q[d].push_back(8'h20); end
                else       begin exp_q[d].push_back(8'h20); exp_q[d].push_back(8'h5D); end
            end
            exp_q[d].push_back(8'h0D); exp_q[d].push_back(8'h0A);
        end
        exp_q[d].push_back(8'h0D); exp_q[d].push_back(8'h0A);
    endtask

    task automatic launch(input int d, input logic [511:0] m);
        @(negedge clk);
        mat[d]   = m;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        chk("busy_after_start", int'(busy[d]), 1);
    endtask

    task automatic wait_bytes(input int d, input int n);
        int t = 0;
        while (n_tx[d] < n && t < 4000) begin @(negedge clk); t++; end
        chk("byte_wait", int'(n_tx[d] >= n), 1);
    endtask

    task automatic wait_done(input int d, input int L, input int base_tx, input int base_done);
        int t = 0;
        while (done_cnt[d] == base_done && t < 8000) begin @(negedge clk); t++; end
        chk("done_seen", int'(done_cnt[d] > base_done), 1);
        chk("byte_count", n_tx[d] - base_tx, L);
        @(negedge clk);
        chk("busy_after_done", int'(busy[d]), 0);
    endtask

    task automatic run_msg(input int d, input logic [511:0] m, input int D, input int L);
        int bt, bd;
        push_text(d, m, D);
        bt = n_tx[d];
        bd = done_cnt[d];
        launch(d, m);
        wait_done(d, L, bt, bd);
    endtask

    function automatic logic [511:0] rand_mat();
        logic [511:0] m;
        for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom;
        return m;
    endfunction

    logic [511:0] ident;
    logic [511:0] m2;
    int bt, bd;

    initial begin
        rst_n = 1'b0;
        start = '0;
        hold  = '0;
        mat[0] = '0;
        mat[1] = '0;
        ident = '0;
        for (int i = 0; i < 4; i++) ident[(5*i)*32] = 1'b1;
        #2;
        chk("rst_transmit", int'(transmit[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_done", int'(done[0]), 0);
        chk("rst_tx_byte", int'(txb[0]), 0);
        chk("rst_busy_d2", int'(busy[1]), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Identity matrix.
        run_msg(0, ident, 4, L4);

        // Truncated wide element plus uppercase digits.
        m2 = '0;
        for (int i = 0; i < 16; i++) m2[i*32 +: 32] = 32'h0000000A;
        m2[31:0] = 32'hABCDEF12;
        run_msg(0, m2, 4, L4);

        // UART busy when start arrives: nothing may go out until it drops.
        hold[0] = 1'b1;
        push_text(0, ident, 4);
        bt = n_tx[0]; bd = done_cnt[0];
        launch(0, ident);
        repeat (50) @(negedge clk);
        chk("no_tx_during_hold", n_tx[0] - bt, 0);
        hold[0] = 1'b0;
        wait_done(0, L4, bt, bd);

        // Second start and new matrix mid-message must be ignored.
        push_text(0, ident, 4);
        bt = n_tx[0]; bd = done_cnt[0];
        launch(0, ident);
        wait_bytes(0, bt + 40);
        mat[0]   = rand_mat();
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, L4, bt, bd);
        repeat (200) @(negedge clk);
        chk("single_done", done_cnt[0] - bd, 1);
        chk("no_bytes_after_done", n_tx[0] - bt, L4);

        // Reset in the middle of a message aborts it.
        m2 = rand_mat();
        push_text(0, m2, 4);
        bt = n_tx[0];
        launch(0, m2);
        wait_bytes(0, bt + 70);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_transmit", int'(transmit[0]), 0);
        chk("midrst_busy", int'(busy[0]), 0);
        chk("midrst_done", int'(done[0]), 0);
        exp_q[0].delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_msg(0, rand_mat(), 4, L4);
        run_msg(0, rand_mat(), 4, L4);

        // Two-digit instance: truncation of 0x01FF to FF and the shorter message.
        m2 = rand_mat();
        m2[31:0] = 32'h000001FF;
        run_msg(1, m2, 2, L2);
        run_msg(1, rand_mat(), 2, L2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
